gshare_predictor: RTL and testbench



---
 rtl/gshare_predictor.sv | 121 ++++++++++++
 tb/tb_gshare_predictor.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare_predictor
// Branch direction predictor: a table of saturating counters indexed by the
// request PC XORed with a global history of resolved outcomes. With
// HIST_W = 0 there is no history register and the table is indexed by PC
// alone (bimodal). Predictions are registered; training arrives later from
// execute carrying the index that was handed out with the prediction.

module gshare_predictor #(
    parameter int IDX_W    = 4,
    parameter int CTR_W    = 2,
    parameter int HIST_W   = 4,
    parameter int CTR_INIT = (1 << CTR_W) - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    // lookup side (fetch)
    input  logic             req_valid,
    input  logic [IDX_W-1:0] req_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    // training side (execute)
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int               DEPTH   = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'(CTR_INIT);

    // Counter table and prediction output registers.
    logic [CTR_W-1:0] r_ctr [DEPTH];
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [IDX_W-1:0] r_pred_idx;

    // History zero-extended to the index width, lookup index, and the
    // trained value of the counter addressed by the update port.
    logic [IDX_W-1:0] w_ghr_ext;
    logic [IDX_W-1:0] w_idx;
    logic [CTR_W-1:0] w_upd_cur;
    logic [CTR_W-1:0] w_upd_next;

    generate
        if (HIST_W > 0) begin : g_hist
            logic [HIST_W-1:0] r_ghr;

            // Global history: shift the resolved outcome in at the LSB on
            // every training strobe (non-speculative). Truncating the
            // concatenation drops the oldest bit and also covers HIST_W = 1.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ghr <= '0;
                end else if (upd_valid) begin
                    // NOTE: sequential state always uses non-blocking
                    // assignments so every register samples pre-edge values.
                    r_ghr <= HIST_W'({r_ghr, upd_taken});
                end
            end

            assign w_ghr_ext = IDX_W'(r_ghr);
        end else begin : g_bimodal
            assign w_ghr_ext = '0;
        end
    endgenerate

    assign w_idx = req_pc ^ w_ghr_ext;

    // Saturating increment/decrement of the counter being trained.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned (which would infer a latch).
        w_upd_cur  = r_ctr[upd_idx];
        w_upd_next = w_upd_cur;
        if (upd_taken) begin
            if (w_upd_cur != CTR_MAX) begin
                w_upd_next = w_upd_cur + 1'b1;
            end
        end else begin
            if (w_upd_cur != '0) begin
                w_upd_next = w_upd_cur - 1'b1;
            end
        end
    end

    // Counter table: every entry returns to CTR_INIT on reset; one entry is
    // trained per strobe. upd_idx is used as-is, history is not re-applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the table is reset entry by entry because predictions
            // must start from a known bias; this makes it flops, not a RAM.
            for (int i = 0; i < DEPTH; i++) begin
                r_ctr[i] <= CTR_RST;
            end
        end else if (upd_valid) begin
            r_ctr[upd_idx] <= w_upd_next;
        end
    end

    // Prediction registers: a lookup reads the pre-edge table and history,
    // so a same-edge training result is only seen by later lookups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
        end else begin
            r_pred_valid <= req_valid;
            if (req_valid) begin
                r_pred_taken <= r_ctr[w_idx][CTR_W-1];
                r_pred_idx   <= w_idx;
            end
        end
    end

    assign pred_valid = r_pred_valid;
    assign pred_taken = r_pred_taken;
    assign pred_idx   = r_pred_idx;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor
// Directed bench for gshare_predictor. Three instances share clock and
// reset: dut_a uses the default gshare configuration, dut_b is bimodal
// (HIST_W = 0), dut_c uses 3-bit counters starting at 4 (bimodal).

module tb_gshare_predictor;

    logic clk;
    logic rst_n;

    // dut_a: IDX_W=4, CTR_W=2, HIST_W=4, CTR_INIT=3
    logic       a_req_valid, a_upd_valid, a_upd_taken;
    logic [3:0] a_req_pc, a_upd_idx;
    logic       a_pred_valid, a_pred_taken;
    logic [3:0] a_pred_idx;

    // dut_b: IDX_W=4, CTR_W=2, HIST_W=0, CTR_INIT=3
    logic       b_req_valid, b_upd_valid, b_upd_taken;
    logic [3:0] b_req_pc, b_upd_idx;
    logic       b_pred_valid, b_pred_taken;
    logic [3:0] b_pred_idx;

    // dut_c: IDX_W=4, CTR_W=3, HIST_W=0, CTR_INIT=4
    logic       c_req_valid, c_upd_valid, c_upd_taken;
    logic [3:0] c_req_pc, c_upd_idx;
    logic       c_pred_valid, c_pred_taken;
    logic [3:0] c_pred_idx;

    int n_checks;
    int n_pass;
    int n_fail;

    gshare_predictor #(.IDX_W(4), .CTR_W(2), .HIST_W(4), .CTR_INIT(3)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (a_req_valid),
        .req_pc     (a_req_pc),
        .pred_valid (a_pred_valid),
        .pred_taken (a_pred_taken),
        .pred_idx   (a_pred_idx),
        .upd_valid  (a_upd_valid),
        .upd_idx    (a_upd_idx),
        .upd_taken  (a_upd_taken)
    );

    gshare_predictor #(.IDX_W(4), .CTR_W(2), .HIST_W(0), .CTR_INIT(3)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (b_req_valid),
        .req_pc     (b_req_pc),
        .pred_valid (b_pred_valid),
        .pred_taken (b_pred_taken),
        .pred_idx   (b_pred_idx),
        .upd_valid  (b_upd_valid),
        .upd_idx    (b_upd_idx),
        .upd_taken  (b_upd_taken)
    );

    gshare_predictor #(.IDX_W(4), .CTR_W(3), .HIST_W(0), .CTR_INIT(4)) dut_c (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (c_req_valid),
        .req_pc     (c_req_pc),
        .pred_valid (c_pred_valid),
        .pred_taken (c_pred_taken),
        .pred_idx   (c_pred_idx),
        .upd_valid  (c_upd_valid),
        .upd_idx    (c_upd_idx),
        .upd_taken  (c_upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports tag/observed/expected on failure.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs may change and outputs are sampled
    // 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle lookup on a given instance (0=a, 1=b, 2=c).
    task automatic lookup(input int which, input logic [3:0] pc);
        case (which)
            0: begin a_req_valid = 1'b1; a_req_pc = pc; end
            1: begin b_req_valid = 1'b1; b_req_pc = pc; end
            default: begin c_req_valid = 1'b1; c_req_pc = pc; end
        endcase
        tick();
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        c_req_valid = 1'b0;
    endtask

    // Single-cycle training strobe on a given instance.
    task automatic train(input int which, input logic [3:0] idx, input logic taken);
        case (which)
            0: begin a_upd_valid = 1'b1; a_upd_idx = idx; a_upd_taken = taken; end
            1: begin b_upd_valid = 1'b1; b_upd_idx = idx; b_upd_taken = taken; end
            default: begin c_upd_valid = 1'b1; c_upd_idx = idx; c_upd_taken = taken; end
        endcase
        tick();
        a_upd_valid = 1'b0;
        b_upd_valid = 1'b0;
        c_upd_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        a_req_valid = 1'b0; a_req_pc = '0; a_upd_valid = 1'b0; a_upd_idx = '0; a_upd_taken = 1'b0;
        b_req_valid = 1'b0; b_req_pc = '0; b_upd_valid = 1'b0; b_upd_idx = '0; b_upd_taken = 1'b0;
        c_req_valid = 1'b0; c_req_pc = '0; c_upd_valid = 1'b0; c_upd_idx = '0; c_upd_taken = 1'b0;

        // ---- reset values
        #3;
        check("rst_pred_valid", 32'(a_pred_valid), 32'd0);
        check("rst_pred_taken", 32'(a_pred_taken), 32'd0);
        check("rst_pred_idx",   32'(a_pred_idx),   32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ---- first lookup after reset: counters at 3, ghr 0
        lookup(0, 4'd5);
        check("first_valid", 32'(a_pred_valid), 32'd1);
        check("first_taken", 32'(a_pred_taken), 32'd1);
        check("first_idx",   32'(a_pred_idx),   32'd5);
        tick();
        check("idle_valid", 32'(a_pred_valid), 32'd0);
        check("idle_taken_hold", 32'(a_pred_taken), 32'd1);
        check("idle_idx_hold",   32'(a_pred_idx),   32'd5);

        // ---- history indexing: outcomes 1,0,1,1 -> ghr 4'b1011
        train(0, 4'd0, 1'b1);
        train(0, 4'd0, 1'b0);
        train(0, 4'd0, 1'b1);
        train(0, 4'd0, 1'b1);
        lookup(0, 4'd3);
        check("hist_idx",   32'(a_pred_idx),   32'd8);
        check("hist_taken", 32'(a_pred_taken), 32'd1);
        check("hist_valid", 32'(a_pred_valid), 32'd1);

        // ---- hysteresis and saturation at 0 (bimodal), idx 5
        train(1, 4'd5, 1'b0);                    // 3 -> 2
        lookup(1, 4'd5);
        check("hyst_after1", 32'(b_pred_taken), 32'd1);
        check("bimodal_idx", 32'(b_pred_idx),   32'd5);
        train(1, 4'd5, 1'b0);                    // 2 -> 1
        lookup(1, 4'd5);
        check("hyst_after2", 32'(b_pred_taken), 32'd0);
        train(1, 4'd5, 1'b0);                    // 1 -> 0
        train(1, 4'd5, 1'b0);                    // 0 stays 0
        train(1, 4'd5, 1'b1);                    // 0 -> 1
        lookup(1, 4'd5);
        check("sat0_then_inc1", 32'(b_pred_taken), 32'd0);
        train(1, 4'd5, 1'b1);                    // 1 -> 2
        lookup(1, 4'd5);
        check("sat0_then_inc2", 32'(b_pred_taken), 32'd1);
        // saturation at 3: three more taken, then one not-taken -> 2
        train(1, 4'd5, 1'b1);
        train(1, 4'd5, 1'b1);
        train(1, 4'd5, 1'b1);
        lookup(1, 4'd5);
        check("sat3_taken", 32'(b_pred_taken), 32'd1);
        train(1, 4'd5, 1'b0);
        lookup(1, 4'd5);
        check("sat3_then_dec", 32'(b_pred_taken), 32'd1);

        // ---- same-edge lookup and training (bimodal), idx 2
        train(1, 4'd2, 1'b0);                    // 3 -> 2
        b_req_valid = 1'b1; b_req_pc = 4'd2;
        b_upd_valid = 1'b1; b_upd_idx = 4'd2; b_upd_taken = 1'b0;   // 2 -> 1
        tick();
        b_req_valid = 1'b0; b_upd_valid = 1'b0;
        check("collide_old_value", 32'(b_pred_taken), 32'd1);
        lookup(1, 4'd2);
        check("collide_next", 32'(b_pred_taken), 32'd0);

        // ---- 3-bit counters, init 4
        lookup(2, 4'd1);
        check("c3_init", 32'(c_pred_taken), 32'd1);
        train(2, 4'd1, 1'b0);                    // 4 -> 3
        lookup(2, 4'd1);
        check("c3_flip", 32'(c_pred_taken), 32'd0);
        train(2, 4'd2, 1'b1);                    // 4 -> 5
        train(2, 4'd2, 1'b1);                    // 5 -> 6
        train(2, 4'd2, 1'b1);                    // 6 -> 7
        train(2, 4'd2, 1'b1);                    // 7 stays
        train(2, 4'd2, 1'b0);                    // 6
        train(2, 4'd2, 1'b0);                    // 5
        train(2, 4'd2, 1'b0);                    // 4
        lookup(2, 4'd2);
        check("c3_sat7_then_dec3", 32'(c_pred_taken), 32'd1);
        train(2, 4'd2, 1'b0);                    // 3
        lookup(2, 4'd2);
        check("c3_sat7_then_dec4", 32'(c_pred_taken), 32'd0);

        // ---- mid-operation reset on dut_a
        // ghr is 1011 here; three not-taken outcomes shift it to 1000.
        train(0, 4'd7, 1'b0);
        train(0, 4'd7, 1'b0);
        train(0, 4'd7, 1'b0);
        lookup(0, 4'd15);                        // 15 ^ 8 = 7
        check("pre_rst_idx",   32'(a_pred_idx),   32'd7);
        check("pre_rst_taken", 32'(a_pred_taken), 32'd0);
        a_req_valid = 1'b1; a_req_pc = 4'd7;
        tick();
        check("pre_rst_valid", 32'(a_pred_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(a_pred_valid), 32'd0);
        check("midrst_idx",   32'(a_pred_idx),   32'd0);
        #1;
        rst_n = 1'b1;
        a_req_valid = 1'b0;
        lookup(0, 4'd7);
        check("post_rst_valid", 32'(a_pred_valid), 32'd1);
        check("post_rst_taken", 32'(a_pred_taken), 32'd1);
        check("post_rst_idx",   32'(a_pred_idx),   32'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
